calc_mem: RTL
=============

CALC_MEM -- requirements
Module: calc_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of 16-bit words stored.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port oe  input  1  read request from the calculator controller.
REQ-005 SHALL have port we  input  1  write request from the calculator controller.
REQ-006 SHALL have port mem_addr  input  16  word address.
REQ-007 SHALL have port mem_data_in  input  16  write data from the controller.
REQ-008 SHALL have port mem_data_out  output  16  read data to the controller.
REQ-009 SHALL have port rd_valid  output  1  mem_data_out holds a valid read result this cycle.
REQ-010 SHALL have port busy  output  1  initialisation sweep in progress; requests are ignored.
REQ-011 SHALL have port addr_err  output  1  the previous request used an out-of-range address or oe and we together.
REQ-012 SHALL have port par_err  output  1  parity mismatch on the read returned this cycle.

Function
REQ-013 SHALL implement FSM states INIT and READY only.
REQ-014 SHALL enter INIT on reset and hold it for exactly DEPTH cycles.
- During INIT, a sweep counter 0..DEPTH-1 writes 0 into each word.
- The FSM SHALL then go to READY.
REQ-015 SHALL drive busy=1 in INIT and busy=0 in READY.
REQ-016 SHALL treat mem_addr >= DEPTH as out of range.
REQ-017 SHALL perform a write in READY when we=1, oe=0 and the address is in range: mem[mem_addr] <= mem_data_in at that edge.
REQ-018 SHALL perform a read in READY when oe=1, we=0 and the address is in range.
- Read latency is 1 cycle: mem_data_out and rd_valid are registered.
- rd_valid is high for exactly one cycle per accepted read.
REQ-019 SHALL return pre-write data when a read hits an address written in the same cycle. Reads are read-before-write; at most one request is accepted per cycle.
REQ-020 SHALL, when oe=1 and we=1 together in READY, perform neither access, assert addr_err the next cycle, and keep rd_valid=0.
REQ-021 SHALL, for an out-of-range address, perform no access, leave memory unchanged, assert addr_err for 1 cycle, keep rd_valid=0 and drive mem_data_out=0.
REQ-022 SHALL drive mem_data_out=0 whenever rd_valid=0.
REQ-023 SHALL ignore oe and we while busy=1: no memory change, rd_valid=0, addr_err=0.
REQ-024 SHALL support back-to-back reads on consecutive cycles, each returning its own address's data with rd_valid held high.

Reset
REQ-025 SHALL, on any edge with reset=0 (including mid-read or mid-sweep), set:
- state=INIT and the sweep counter to 0;
- rd_valid=0, addr_err=0, par_err=0, mem_data_out=0;
- busy=1 from the next cycle.
REQ-026 SHALL make all stored contents 0 once the post-reset sweep completes.

Configuration
REQ-027 SHALL use macro CALC_MEM_PARITY_EN to select parity checking.
- Defined: each word stores an extra even-parity bit computed on write. On read, par_err is asserted, aligned with rd_valid, when the recomputed parity differs from the stored bit. Data is still returned.
- Undefined: no parity storage; par_err is tied to 0.

Structure
REQ-028 SHALL place the following in package calc_mem_pkg:
- localparam DEPTH_DEFAULT=16;
- function addr_in_range;
- typedef enum logic {INIT, READY} calc_mem_state_t.
REQ-029 SHALL keep the storage array (with the optional parity column) in sub-module calc_mem_array.
- Ports: clk, write enable, address, write data, registered read data.
- The control FSM, decoding and error flags stay in calc_mem.

Verification
REQ-030 Reset, then wait 16 cycles. -> busy=1 for cycles 1-16, then 0. A read of every address returns 0x0000.
REQ-031 Write 0x1234 to addr 3, then oe on addr 3. -> Next cycle: rd_valid=1, mem_data_out=0x1234, par_err=0.
REQ-032 oe and we both high on addr 5 with data 0xFFFF. -> addr_err=1 for 1 cycle, rd_valid=0, and a later read of addr 5 returns 0x0000.
REQ-033 Write to addr 16 (DEPTH=16). -> addr_err=1, and no word changes. Reads of 0-15 are unchanged.
REQ-034 Reads to addrs 1,2,3 on consecutive cycles after writing 0xA,0xB,0xC. -> rd_valid high for 3 cycles returning 0x000A,0x000B,0x000C.
REQ-035 Assert reset mid-read after writing 0xBEEF to addr 7. -> rd_valid=0 next cycle, busy=1. After the sweep, addr 7 reads 0x0000. With CALC_MEM_PARITY_EN, forcing a stored parity bit flip makes par_err=1 with rd_valid.

Source files
------------

// File: rtl/calc_mem_pkg.sv
// rtl/calc_mem_pkg.sv - shared types, defaults and address check for calc_mem
package calc_mem_pkg;

  localparam int DEPTH_DEFAULT = 16;

  typedef enum logic {INIT, READY} calc_mem_state_t;

  function automatic logic addr_in_range(input logic [15:0] addr, input int unsigned depth);
    return {16'd0, addr} < depth;
  endfunction

endpackage

// File: rtl/calc_mem_array.sv
// rtl/calc_mem_array.sv - word storage with registered read; CALC_MEM_PARITY_EN adds a parity column
module calc_mem_array #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wr_data,
`ifdef CALC_MEM_PARITY_EN
  output logic          rd_par,
`endif
  output logic [15:0]   rd_data
);

  logic [15:0] mem [DEPTH];
  logic [15:0] rd_data_q;
  logic [15:0] rd_data_d;

  // The read samples the array before this edge's write lands: read-before-write.
  always_comb begin
    rd_data_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

`ifdef CALC_MEM_PARITY_EN
  logic par_mem [DEPTH];
  logic rd_par_q;
  logic rd_par_d;

  always_comb begin
    rd_par_d = par_mem[addr];
  end

  always_ff @(posedge clk) begin
    rd_par_q <= rd_par_d;
    if (wr_en) begin
      par_mem[addr] <= ^wr_data;
    end
  end

  assign rd_par = rd_par_q;
`endif

endmodule

// File: rtl/calc_mem.sv
// rtl/calc_mem.sv - calculator memory: init sweep FSM, request decode, error flags
// Optional parity checking selected by CALC_MEM_PARITY_EN.
module calc_mem
  import calc_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        oe,
  input  logic        we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data_in,
  output logic [15:0] mem_data_out,
  output logic        rd_valid,
  output logic        busy,
  output logic        addr_err,
  output logic        par_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  calc_mem_state_t state_q, state_d;
  logic [AW-1:0]   sweep_q, sweep_d;
  logic            rd_valid_q, rd_valid_d;
  logic            addr_err_q, addr_err_d;

  logic            in_range;
  logic            arr_we;
  logic [AW-1:0]   arr_addr;
  logic [15:0]     arr_wdata;
  logic [15:0]     rd_data;

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    arr_we     = 1'b0;
    arr_addr   = mem_addr[AW-1:0];
    arr_wdata  = mem_data_in;
    in_range   = addr_in_range(mem_addr, DEPTH);

    case (state_q)
      INIT: begin
        // Requests are ignored here; the port is owned by the zeroing sweep.
        arr_we    = reset;
        arr_addr  = sweep_q;
        arr_wdata = '0;
        sweep_d   = sweep_q + AW'(1);
        if (sweep_q == AW'(DEPTH - 1)) begin
          state_d = READY;
          sweep_d = '0;
        end
      end
      READY: begin
        if (oe && we) begin
          addr_err_d = 1'b1;
        end else if (oe || we) begin
          if (!in_range) begin
            addr_err_d = 1'b1;
          end else if (oe) begin
            rd_valid_d = 1'b1;
          end else begin
            arr_we = reset;
          end
        end
      end
      default: begin
        state_d = INIT;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= INIT;
      sweep_q    <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

`ifdef CALC_MEM_PARITY_EN
  logic rd_par;

  calc_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .wr_en   (arr_we),
    .addr    (arr_addr),
    .wr_data (arr_wdata),
    .rd_par  (rd_par),
    .rd_data (rd_data)
  );

  assign par_err = rd_valid_q && ((^rd_data) != rd_par);
`else
  calc_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .wr_en   (arr_we),
    .addr    (arr_addr),
    .wr_data (arr_wdata),
    .rd_data (rd_data)
  );

  assign par_err = 1'b0;
`endif

  assign mem_data_out = rd_valid_q ? rd_data : '0;
  assign rd_valid     = rd_valid_q;
  assign addr_err     = addr_err_q;
  assign busy         = (state_q == INIT);

endmodule
